imem_responder: RTL and testbench

- Memory-side responder for the fetch stage's instruction-memory interface. The fetch stage acts as initiator: it presents a word-aligned PC, and this block answers after a parameterised latency.
- Replaces the single-cycle memory model so the datapath can be exercised with multi-cycle memory.
- Drives `stall` back to the fetch stage so the PC register holds while a response is pending.
- Supports writes so a bench or loader can preload the program image through the same port.

---
 rtl/imem_responder_pkg.sv | 18 +
 rtl/imem_responder_latency_counter.sv | 26 ++
 rtl/imem_responder.sv | 134 +++++++++++++
 tb/tb_imem_responder.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/imem_responder_pkg.sv
// rtl/imem_responder_pkg.sv - shared types and constants for the instruction-memory responder
package imem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  // Same increment the fetch adder applies to the PC.
  localparam int WORD_BYTES = 2;
  localparam int CNT_W      = 4;

  function automatic bit latency_legal(input int lat);
    return (lat >= 1) && (lat <= 15);
  endfunction

endpackage

// File: rtl/imem_responder_latency_counter.sv
// rtl/imem_responder_latency_counter.sv - loadable down-counter with zero flag
module latency_counter
  import imem_responder_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - multi-cycle instruction-memory responder answering the fetch stage
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_data,
  output logic        stall,
  output logic        done,
  output logic [15:0] data_out,
  output logic        err
);

  localparam int ADDR_LSB = $clog2(WORD_BYTES);
  localparam int WORDS    = 1 << DEPTH_LOG2;
  localparam bit MULTI    = (LATENCY > 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = MULTI ? CNT_W'(LATENCY - 2) : '0;

  if (!latency_legal(LATENCY)) begin : g_bad_latency
    $error("imem_responder: LATENCY must be within 1..15");
  end

  state_t state, next_state;

  logic                  accepting;
  logic                  accept;
  logic                  misaligned;
  logic                  counter_load;
  logic                  counter_dec;
  logic                  counter_zero;
  logic [CNT_W-1:0]      unused_count;
  logic                  unused_addr_bits;
  logic                  access;
  logic                  acc_wr;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic [15:0]           acc_data;
  logic [DEPTH_LOG2-1:0] req_idx;
  logic                  cap_wr;
  logic [DEPTH_LOG2-1:0] cap_idx;
  logic [15:0]           cap_data;
  logic [15:0]           mem [WORDS];

  assign accepting  = (state == IDLE) || (state == DONE);
  assign accept     = accepting & req_valid;
  assign misaligned = req_addr[0];
  // High address bits are dropped on purpose so accesses wrap around the array.
  assign req_idx          = req_addr[ADDR_LSB +: DEPTH_LOG2];
  assign unused_addr_bits = ^req_addr[15:ADDR_LSB+DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          next_state = (misaligned || !MULTI) ? DONE : BUSY;
        end
      end
      BUSY:    next_state = counter_zero ? DONE : BUSY;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    counter_load = accept & MULTI & ~misaligned;
    counter_dec  = (state == BUSY);
    stall        = (state == BUSY) | counter_load;
    access       = (next_state == DONE) && !(accept && misaligned);
    // A single-cycle access has no captured request yet, so it uses the live inputs.
    if (state == BUSY) begin
      acc_wr   = cap_wr;
      acc_idx  = cap_idx;
      acc_data = cap_data;
    end else begin
      acc_wr   = req_wr;
      acc_idx  = req_idx;
      acc_data = req_data;
    end
  end

  latency_counter u_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (counter_load),
    .load_val (LOAD_VAL),
    .dec      (counter_dec),
    .count    (unused_count),
    .zero     (counter_zero)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      cap_wr   <= req_wr;
      cap_idx  <= req_idx;
      cap_data <= req_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && access && acc_wr) begin
      mem[acc_idx] <= acc_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done     <= 1'b0;
      err      <= 1'b0;
      data_out <= '0;
    end else begin
      done <= (next_state == DONE);
      err  <= accept & misaligned;
      if (accept && misaligned) begin
        data_out <= '0;
      end else if (access) begin
        data_out <= acc_wr ? 16'h0000 : mem[acc_idx];
      end
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - randomized self-checking bench for imem_responder at LATENCY 4 and 1
module tb_imem_responder;

  logic        clk;
  logic        rst;
  logic        rv   [2];
  logic        rw   [2];
  logic [15:0] ra   [2];
  logic [15:0] rd   [2];
  logic        stl  [2];
  logic        dn   [2];
  logic [15:0] dout [2];
  logic        er   [2];

  int          lat  [2];
  logic [15:0] mdl  [2][256];
  int          n_cmp;
  int          n_mis;
  logic [15:0] got;

  imem_responder #(.DEPTH_LOG2(8), .LATENCY(4)) u_dut_l4 (
    .clk(clk), .rst(rst), .req_valid(rv[0]), .req_wr(rw[0]), .req_addr(ra[0]),
    .req_data(rd[0]), .stall(stl[0]), .done(dn[0]), .data_out(dout[0]), .err(er[0])
  );

  imem_responder #(.DEPTH_LOG2(8), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .req_valid(rv[1]), .req_wr(rw[1]), .req_addr(ra[1]),
    .req_data(rd[1]), .stall(stl[1]), .done(dn[1]), .data_out(dout[1]), .err(er[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request on instance s and follow it to its response. Entered and left
  // 2 time units after a rising edge; on return the instance sits in its done cycle,
  // so the next call issues back-to-back.
  task automatic txn(input int s, input logic wr, input logic [15:0] addr,
                     input logic [15:0] data, output logic [15:0] res);
    int          exp_lat;
    int          idx;
    logic        mis;
    logic [15:0] exp_d;
    bit          seen;
    mis     = addr[0];
    exp_lat = mis ? 1 : lat[s];
    idx     = (addr / 2) % 256;
    exp_d   = (mis || wr) ? 16'h0000 : mdl[s][idx];
    rv[s] = 1'b1; rw[s] = wr; ra[s] = addr; rd[s] = data;
    #1;
    check("stall_accept", 32'(stl[s]), 32'(!mis && lat[s] > 1));
    seen = 0;
    res  = 16'h0000;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (k < exp_lat) begin
        rv[s] = 1'b1; rw[s] = 1'($urandom); ra[s] = 16'($urandom); rd[s] = 16'($urandom);
      end else begin
        rv[s] = 1'b0;
      end
      #1;
      check("stall", 32'(stl[s]), 32'(k < exp_lat));
      check("done", 32'(dn[s]), 32'(k == exp_lat));
      if (dn[s] === 1'b1) begin
        seen = 1;
        check("err", 32'(er[s]), 32'(mis));
        check("data_out", 32'(dout[s]), 32'(exp_d));
        res = dout[s];
        if (!mis && wr) mdl[s][idx] = data;
      end
    end
    if (!seen) check("timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    rv[0] = 1'b0;
    rv[1] = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    lat[0] = 4;
    lat[1] = 1;
    for (int s = 0; s < 2; s++) begin
      rv[s] = 1'b0; rw[s] = 1'b0; ra[s] = 16'h0; rd[s] = 16'h0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      check("reset_done", 32'(dn[s]), 32'd0);
      check("reset_err", 32'(er[s]), 32'd0);
      check("reset_data", 32'(dout[s]), 32'd0);
      check("reset_stall", 32'(stl[s]), 32'd0);
    end

    // Preload every word through the request port.
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 256; i++)
        txn(s, 1'b1, 16'(i * 2), 16'($urandom), got);

    // Directed sequence at LATENCY 4.
    txn(0, 1'b1, 16'h0000, 16'h1234, got);
    txn(0, 1'b1, 16'h0002, 16'hABCD, got);
    idle(2);
    txn(0, 1'b0, 16'h0002, 16'h0000, got);
    check("read_0002", 32'(got), 32'h0000ABCD);
    txn(0, 1'b1, 16'h0003, 16'hEEEE, got);
    txn(0, 1'b0, 16'h0002, 16'h0000, got);
    check("after_misaligned", 32'(got), 32'h0000ABCD);
    txn(0, 1'b0, 16'h0000, 16'h0000, got);
    check("back_to_back", 32'(got), 32'h00001234);
    idle(1);

    // Reset in the middle of a pending write.
    rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 16'h0004; rd[0] = 16'h5555;
    @(posedge clk); #1 rv[0] = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    #1 check("busy_before_reset", 32'(stl[0]), 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    #1;
    check("rst_mid_done", 32'(dn[0]), 32'd0);
    check("rst_mid_err", 32'(er[0]), 32'd0);
    check("rst_mid_data", 32'(dout[0]), 32'd0);
    check("rst_mid_stall", 32'(stl[0]), 32'd0);
    @(posedge clk); #2;
    check("rst_no_late_done", 32'(dn[0]), 32'd0);
    txn(0, 1'b0, 16'h0004, 16'h0000, got);
    check("write_dropped", 32'(got == 16'h5555 && mdl[0][2] != 16'h5555), 32'd0);

    // LATENCY 1: single read, then a PC sweep with one request per cycle.
    txn(1, 1'b1, 16'h0000, 16'h1234, got);
    txn(1, 1'b0, 16'h0000, 16'h0000, got);
    check("l1_read_0000", 32'(got), 32'h00001234);
    for (int pc = 0; pc <= 16'h000E; pc += 2)
      txn(1, 1'b0, 16'(pc), 16'h0000, got);
    idle(1);

    // Wrap: 0x0200 aliases word 0 with 256 words.
    txn(0, 1'b1, 16'h0200, 16'h7777, got);
    txn(0, 1'b0, 16'h0000, 16'h0000, got);
    check("wrap_read", 32'(got), 32'h00007777);

    // Randomized traffic against the array model.
    for (int s = 0; s < 2; s++) begin
      for (int n = 0; n < 80; n++) begin
        logic        wr;
        logic [15:0] addr;
        wr   = ($urandom_range(2) == 0);
        addr = 16'($urandom) & 16'hFFFE;
        if ($urandom_range(7) == 0) addr[0] = 1'b1;
        txn(s, wr, addr, 16'($urandom), got);
        if ($urandom_range(1) == 0) idle($urandom_range(2));
      end
      idle(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
